// File: rtl/uart7n_pkg.sv
// Shared uart7n types and constants: TX state encoding, parity/stop selectors, bit-period helper.
package uart7n_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } tx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
    localparam logic STOP_ONE    = 1'b0;
    localparam logic STOP_TWO    = 1'b1;

    // Clocks per line bit, rounded to nearest.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart7n_baud_tick.sv
// Bit-period timer: free-running 0..p_div-1, restarted by clr; tick marks the last clock of a bit.
module uart7n_baud_tick #(
    parameter int unsigned p_div = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (p_div > 1) ? $clog2(p_div) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (cnt == CW'(p_div - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CW'(p_div - 1));

endmodule

// File: rtl/uart7n_tx.sv
// 7-bit UART transmitter with optional even/odd parity and one or two stop bits.
// Request is taken only in IDLE; all outputs are registered so the line never glitches.
module uart7n_tx
    import uart7n_pkg::*;
#(
    parameter int unsigned p_clk_speed_hz = 50_000_000,
    parameter int unsigned p_baud_rate    = 115_200
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       enable_tx_i,
    input  logic [6:0] data_tx_i,
    input  logic       parity_en_i,
    input  logic       parity_sel_i,
    input  logic       stop_sel_i,
    output logic       data_o,
    output logic       tx_busy_o,
    output logic       tx_data_sent_o
);

    localparam int unsigned DIV = calc_div(p_clk_speed_hz, p_baud_rate);

    if (DIV < 2) begin : g_div_check
        $error("uart7n_tx: clocks per bit must be at least 2");
    end

    tx_state_t  state, state_nxt;
    logic [2:0] bit_idx, bit_idx_nxt;
    logic [6:0] char_q;
    logic       par_en_q, par_sel_q, stop_two_q;
    logic       tick, accept, par_bit;
    logic       data_nxt, busy_nxt, sent_nxt;

    assign accept  = (state == IDLE) && enable_tx_i;
    assign par_bit = (^char_q) ^ (par_sel_q == PARITY_ODD);

    // Restarting the timer on accept aligns every bit boundary to the accept edge.
    uart7n_baud_tick #(.p_div(DIV)) u_baud (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .clr   (accept),
        .tick  (tick)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state          <= IDLE;
            bit_idx        <= '0;
            data_o         <= 1'b1;
            tx_busy_o      <= 1'b0;
            tx_data_sent_o <= 1'b0;
        end else begin
            state          <= state_nxt;
            bit_idx        <= bit_idx_nxt;
            data_o         <= data_nxt;
            tx_busy_o      <= busy_nxt;
            tx_data_sent_o <= sent_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            char_q     <= '0;
            par_en_q   <= 1'b0;
            par_sel_q  <= PARITY_EVEN;
            stop_two_q <= STOP_ONE;
        end else if (accept) begin
            char_q     <= data_tx_i;
            par_en_q   <= parity_en_i;
            par_sel_q  <= parity_sel_i;
            stop_two_q <= stop_sel_i;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_idx_nxt = bit_idx;
        case (state)
            IDLE: begin
                if (enable_tx_i) state_nxt = START;
            end
            START: begin
                if (tick) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == 3'd6) state_nxt = par_en_q ? PARITY : STOP1;
                    else                 bit_idx_nxt = bit_idx + 3'd1;
                end
            end
            PARITY: begin
                if (tick) state_nxt = STOP1;
            end
            STOP1: begin
                if (tick) state_nxt = (stop_two_q == STOP_TWO) ? STOP2 : IDLE;
            end
            STOP2: begin
                if (tick) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so the registered line changes on the bit edge.
    always_comb begin
        data_nxt = 1'b1;
        case (state_nxt)
            START:   data_nxt = 1'b0;
            DATA:    data_nxt = char_q[bit_idx_nxt];
            PARITY:  data_nxt = par_bit;
            default: data_nxt = 1'b1;
        endcase
        busy_nxt = (state_nxt != IDLE);
        sent_nxt = (state != IDLE) && (state_nxt == IDLE);
    end

endmodule

// File: tb/tb_uart7n_tx.sv
// Directed bench for uart7n_tx at 10 clocks per bit; every line clock of every frame is checked.
module tb_uart7n_tx;

    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [6:0] din = '0;
    logic       pen = 1'b0;
    logic       psel = 1'b0;
    logic       ssel = 1'b0;
    logic       dout, busy, sent;
    bit         aborted;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart7n_tx #(
        .p_clk_speed_hz (1_000_000),
        .p_baud_rate    (100_000)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .enable_tx_i    (en),
        .data_tx_i      (din),
        .parity_en_i    (pen),
        .parity_sel_i   (psel),
        .stop_sel_i     (ssel),
        .data_o         (dout),
        .tx_busy_o      (busy),
        .tx_data_sent_o (sent)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_sent);
        check({tag, " line"}, dout, 1'b1);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " sent"}, sent, exp_sent);
    endtask

    // Caller raises en with the frame inputs; the first step is the accept edge.
    // exp lists the line level of each bit in transmit order.
    // Returns in the sent-pulse cycle, or right after the reset edge when aborted.
    task automatic send_frame(input string tag, input string exp, input int inject_at,
                              input int abort_at, output bit was_aborted);
        int   k;
        logic e;
        was_aborted = 1'b0;
        step();
        en = 1'b0;
        for (int b = 0; b < exp.len(); b++) begin
            for (int c = 0; c < DIV; c++) begin
                k = b * DIV + c;
                if (k == abort_at) begin
                    rst_n = 1'b0;
                    step();
                    rst_n = 1'b1;
                    check_idle($sformatf("%s reset k=%0d", tag, k), 1'b0);
                    was_aborted = 1'b1;
                    return;
                end
                if (inject_at >= 0 && k == inject_at + 1) en = 1'b0;
                e = (exp[b] == "1");
                check($sformatf("%s line k=%0d", tag, k), dout, e);
                check($sformatf("%s busy k=%0d", tag, k), busy, 1'b1);
                check($sformatf("%s sent k=%0d", tag, k), sent, 1'b0);
                if (k == inject_at) begin
                    en   = 1'b1;
                    din  = 7'h3E;
                    pen  = 1'b1;
                    psel = 1'b1;
                    ssel = 1'b1;
                end
                step();
            end
        end
        check_idle({tag, " done"}, 1'b1);
    endtask

    initial begin
        // Reset state, both while held and after release.
        step();
        step();
        check_idle("reset held", 1'b0);
        rst_n = 1'b1;
        step();
        check_idle("reset released", 1'b0);
        step();
        check_idle("idle no request", 1'b0);

        // 0x41, no parity, one stop.
        din = 7'h41; pen = 1'b0; psel = 1'b0; ssel = 1'b0; en = 1'b1;
        send_frame("f1 41 n1", "010000011", -1, -1, aborted);
        step();
        check_idle("f1 after", 1'b0);

        // 0x41, even parity (0), two stops.
        din = 7'h41; pen = 1'b1; psel = 1'b0; ssel = 1'b1; en = 1'b1;
        send_frame("f2 41 e2", "01000001011", -1, -1, aborted);
        step();
        check_idle("f2 after", 1'b0);

        // 0x41, odd parity (1), two stops.
        din = 7'h41; pen = 1'b1; psel = 1'b1; ssel = 1'b1; en = 1'b1;
        send_frame("f3 41 o2", "01000001111", -1, -1, aborted);
        step();
        check_idle("f3 after", 1'b0);

        // 0x7F, even parity over seven ones gives 1.
        din = 7'h7F; pen = 1'b1; psel = 1'b0; ssel = 1'b0; en = 1'b1;
        send_frame("f4 7F e1", "0111111111", -1, -1, aborted);
        step();
        check_idle("f4 after", 1'b0);

        // 0x00, odd parity gives 1; line low for 80 clocks.
        din = 7'h00; pen = 1'b1; psel = 1'b1; ssel = 1'b0; en = 1'b1;
        send_frame("f5 00 o1", "0000000011", -1, -1, aborted);
        step();
        check_idle("f5 after", 1'b0);

        // Request plus changed data/framing at clock 30 must not disturb the frame.
        din = 7'h41; pen = 1'b0; psel = 1'b0; ssel = 1'b0; en = 1'b1;
        send_frame("f6 ignore", "010000011", 30, -1, aborted);
        step();
        check_idle("f6 after", 1'b0);
        step();
        check_idle("f6 no retrigger", 1'b0);

        // Back-to-back: request raised in the sent cycle starts the next frame at once.
        din = 7'h41; pen = 1'b0; psel = 1'b0; ssel = 1'b0; en = 1'b1;
        send_frame("f7a 41", "010000011", -1, -1, aborted);
        din = 7'h55; en = 1'b1;
        send_frame("f7b 55", "010101011", -1, -1, aborted);
        step();
        check_idle("f7 after", 1'b0);

        // Reset for one clock during DATA bit 3 abandons the frame with no sent pulse.
        din = 7'h55; pen = 1'b0; psel = 1'b0; ssel = 1'b0; en = 1'b1;
        send_frame("f8 abort", "010101011", -1, 45, aborted);
        for (int i = 0; i < 15; i++) begin
            step();
            check_idle($sformatf("f8 quiet %0d", i), 1'b0);
        end

        // Fresh request after the abort: 0x2A, even parity (1), one stop.
        din = 7'h2A; pen = 1'b1; psel = 1'b0; ssel = 1'b0; en = 1'b1;
        send_frame("f9 2A e1", "0010101011", -1, -1, aborted);
        step();
        check_idle("f9 after", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart7n_tx.md
Name: uart7n_tx

Overview:
- 7-bit UART transmitter: serialises one 7-bit character per request.
- Optional parity bit (even or odd) and one or two stop bits.
- Transmit-side counterpart of the uart7n receiver; same framing, parity and stop conventions, so TX->RX loopback is lossless.
- Sits inside the uart7n top alongside the receiver; driven by user logic through a pulse-request / done-pulse handshake.

Parameters:
- p_clk_speed_hz, 50_000_000, input clock frequency in Hz.
- p_baud_rate, 115_200, line bit rate.
- Derived constant DIV = (p_clk_speed_hz + p_baud_rate/2) / p_baud_rate, i.e. clocks per bit, rounded to nearest (434 at defaults). DIV >= 2 is required; elaboration fails otherwise.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset, synchronous, active-low
- enable_tx_i  in  1  transmit request; sampled every clock, acted on only in IDLE
- data_tx_i  in  7  character to send; captured on the accept cycle
- parity_en_i  in  1  1 = parity bit inserted after the data bits
- parity_sel_i  in  1  0 = even parity, 1 = odd parity
- stop_sel_i  in  1  0 = one stop bit, 1 = two stop bits
- data_o  out  1  serial line; idle high
- tx_busy_o  out  1  high while a frame is in progress
- tx_data_sent_o  out  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (rst_n_i low at a clk_i edge):
  - data_o=1, tx_busy_o=0, tx_data_sent_o=0.
  - State goes to IDLE; bit counter and baud counter clear.
  - Applies mid-frame too: the line returns high on the next edge, the frame is abandoned and no sent pulse is issued.
- Accept:
  - Condition: IDLE and enable_tx_i=1 at edge N.
  - data_tx_i, parity_en_i, parity_sel_i and stop_sel_i are latched at edge N. Input changes after N do not affect the frame.
  - From edge N, data_o=0 (start bit) and tx_busy_o=1. Zero-cycle request-to-line latency beyond the registering edge.
- States:
  - IDLE -> START -> DATA -> PARITY (only if parity latched) -> STOP1 -> STOP2 (only if stop_sel latched) -> IDLE.
- Bit timing:
  - Every bit holds data_o for exactly DIV clocks, timed by a baud counter that counts 0..DIV-1.
  - The state advances when the counter reaches DIV-1.
- DATA: 7 bits, LSB first, bit index 0..6; the last bit exits at index 6.
- Parity bit:
  - Even: XOR of the 7 latched bits.
  - Odd: inverse of that XOR.
- Stop bits are 1.
- Frame length = (1 + 7 + P + S) * DIV clocks, where P is 0/1 and S is 1/2. Range is 9*DIV to 11*DIV.
- Completion:
  - On the final stop bit's last clock, the next edge enters IDLE with tx_busy_o=0 and tx_data_sent_o=1 for exactly one cycle. data_o stays 1.
- Back-to-back:
  - enable_tx_i=1 in the cycle tx_data_sent_o is high is accepted.
  - The next start bit then follows the last stop bit with no idle gap.
- enable_tx_i while busy is ignored. It is not queued; a level held high retriggers only after completion.
- All outputs are registered; data_o is glitch-free.

Decomposition:
- Package uart7n_pkg holds:
  - the TX state enum (IDLE, START, DATA, PARITY, STOP1, STOP2);
  - constants PARITY_EVEN=0 and PARITY_ODD=1;
  - STOP_ONE=0 and STOP_TWO=1;
  - a function computing DIV from clock and baud. This is shared with the receiver.
- One sub-module, uart7n_baud_tick:
  - free-running counter 0..DIV-1, cleared on accept;
  - tick output asserted on the count equal to DIV-1.

Test Plan (p_clk_speed_hz=1_000_000, p_baud_rate=100_000, DIV=10):
- 0x41, parity off, 1 stop -> line 0,1,0,0,0,0,0,1,1, 10 clocks each; busy high 90 clocks; one sent pulse at clock 90.
- 0x41, even parity, 2 stop -> parity bit 0, frame 110 clocks. Repeat with odd parity -> parity bit 1.
- 0x7F, even parity -> parity bit 1. Also 0x00 with odd parity -> parity bit 1; line low for 80 clocks (start plus 7 data bits).
- enable_tx_i pulsed at clock 30 of a frame with different data -> ignored: frame bits unchanged, exactly one sent pulse.
- Request issued in the tx_data_sent_o cycle -> start bit immediately follows the stop bit, no gap; two sent pulses exactly one frame apart.
- rst_n_i low for 1 clock during DATA bit 3 -> data_o=1 and busy=0 next edge, no sent pulse; a fresh request afterwards transmits correctly.
